// File: rtl/xadac_pkg.sv
// Shared types and constants for the xadac vector coprocessor slice.
// Holds the opcode, lane geometry, vec_op_e funct3 encoding and request/response payloads.
package xadac_pkg;

  localparam logic [6:0] XadacOpcode = 7'b0001011;
  localparam int VecW  = 32;
  localparam int LaneW = 8;
  localparam int RegW  = 32;

  typedef logic [3:0] IdT;
  typedef logic [4:0] RegIdT;

  typedef enum logic [2:0] {
    VecAdd   = 3'd0,
    VecSub   = 3'd1,
    VecMac   = 3'd2,
    VecBcast = 3'd3,
    VecExt   = 3'd4
  } vec_op_e;

  typedef struct packed {
    IdT          id;
    logic [31:0] instr;
  } dec_req_t;

  typedef struct packed {
    IdT   id;
    logic accept;
    logic vd_clobber;
    logic vs1_read;
    logic vs2_read;
    logic vs3_read;
  } dec_rsp_t;

  typedef struct packed {
    IdT              id;
    logic [31:0]     instr;
    logic [RegW-1:0] rs1;
    logic [VecW-1:0] vs1;
    logic [VecW-1:0] vs2;
    logic [VecW-1:0] vs3;
  } exe_req_t;

  typedef struct packed {
    IdT              id;
    logic [RegW-1:0] rd;
    logic            rd_write;
    logic [VecW-1:0] vd;
    logic            vd_write;
  } exe_rsp_t;

endpackage

// File: rtl/xadac_if.sv
// Decode and execute valid/ready channels between the core (mst) and the coprocessor (slv).
// Each interface carries one request channel and one response channel.
interface xadac_dec_if;
  import xadac_pkg::*;
  logic     req_valid;
  logic     req_ready;
  dec_req_t req;
  logic     rsp_valid;
  logic     rsp_ready;
  dec_rsp_t rsp;

  modport mst (output req_valid, req, rsp_ready, input req_ready, rsp_valid, rsp);
  modport slv (input req_valid, req, rsp_ready, output req_ready, rsp_valid, rsp);
endinterface

interface xadac_exe_if;
  import xadac_pkg::*;
  logic     req_valid;
  logic     req_ready;
  exe_req_t req;
  logic     rsp_valid;
  logic     rsp_ready;
  exe_rsp_t rsp;

  modport mst (output req_valid, req, rsp_ready, input req_ready, rsp_valid, rsp);
  modport slv (input req_valid, req, rsp_ready, output req_ready, rsp_valid, rsp);
endinterface

// File: rtl/xadac_vec_lanes.sv
// Combinational lane arithmetic selected by vec_op_e; lanes wrap modulo 2^LaneW.
// For VecMac the caller supplies a = vs3 and b = the already-registered lane products.
module xadac_vec_lanes
  import xadac_pkg::*;
#(
  parameter int LaneW = xadac_pkg::LaneW
) (
  input  vec_op_e         op,
  input  logic [VecW-1:0] a,
  input  logic [VecW-1:0] b,
  input  logic [RegW-1:0] rs1,
  input  RegIdT           idx,
  output logic [VecW-1:0] vd,
  output logic [RegW-1:0] rd
);

  localparam int Lanes = VecW / LaneW;

  int sel;

  always_comb begin
    vd  = '0;
    rd  = '0;
    sel = int'(idx) % Lanes;
    for (int i = 0; i < Lanes; i++) begin
      unique case (op)
        VecAdd, VecMac: vd[i*LaneW +: LaneW] = a[i*LaneW +: LaneW] + b[i*LaneW +: LaneW];
        VecSub:         vd[i*LaneW +: LaneW] = a[i*LaneW +: LaneW] - b[i*LaneW +: LaneW];
        VecBcast:       vd[i*LaneW +: LaneW] = rs1[LaneW-1:0];
        VecExt:         if (i == sel) rd[LaneW-1:0] = a[i*LaneW +: LaneW];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/xadac_vec_alu.sv
// Vector ALU coprocessor terminating the xadac decode and execute interfaces.
// Define XADAC_VEC_ALU_MAC_EN to build in VMAC (multiplier, BUSY state, latency counter).
module xadac_vec_alu
  import xadac_pkg::*;
#(
  parameter int MacLatency = 3,
  parameter int LaneW      = xadac_pkg::LaneW
) (
  input logic     clk,
  input logic     rstn,
  xadac_dec_if.slv dec_slv,
  xadac_exe_if.slv exe_slv
);

  localparam int Lanes = VecW / LaneW;

  function automatic logic op_supported(logic [31:0] instr);
    logic base;
    base = (instr[6:0] == XadacOpcode) && (instr[31:25] == 7'd0);
    case (instr[14:12])
      3'd0, 3'd1, 3'd3, 3'd4: op_supported = base;
`ifdef XADAC_VEC_ALU_MAC_EN
      3'd2:                   op_supported = base;
`endif
      default:                op_supported = 1'b0;
    endcase
  endfunction

  function automatic dec_rsp_t dec_flags(IdT id, logic [31:0] instr);
    dec_rsp_t r;
    r    = '0;
    r.id = id;
    if (op_supported(instr)) begin
      r.accept = 1'b1;
      unique case (vec_op_e'(instr[14:12]))
        VecAdd, VecSub: {r.vd_clobber, r.vs1_read, r.vs2_read} = 3'b111;
        VecMac:         {r.vd_clobber, r.vs1_read, r.vs2_read, r.vs3_read} = 4'b1111;
        VecBcast:       r.vd_clobber = 1'b1;
        VecExt:         r.vs1_read   = 1'b1;
        default: ;
      endcase
    end
    return r;
  endfunction

  // Decode: one-entry registered response buffer
  logic     dec_pending;
  dec_rsp_t dec_rsp_q;
  logic     dec_hs;

  assign dec_slv.req_ready = !dec_pending || dec_slv.rsp_ready;
  assign dec_slv.rsp_valid = dec_pending && rstn;
  assign dec_slv.rsp       = dec_rsp_q;
  assign dec_hs            = dec_slv.req_valid && dec_slv.req_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dec_pending <= 1'b0;
      dec_rsp_q   <= '0;
    end else if (dec_hs) begin
      dec_pending <= 1'b1;
      dec_rsp_q   <= dec_flags(dec_slv.req.id, dec_slv.req.instr);
    end else if (dec_slv.rsp_ready) begin
      dec_pending <= 1'b0;
    end
  end

  // Execute FSM
`ifdef XADAC_VEC_ALU_MAC_EN
  typedef enum logic [1:0] {StIdle, StBusy, StResp} exe_state_e;
  localparam int CntW = $clog2(MacLatency + 1);

  logic [CntW-1:0] cnt_q;
  logic [VecW-1:0] vs3_p0;
  logic [VecW-1:0] prod_p0;

  function automatic logic [VecW-1:0] lane_mul(logic [VecW-1:0] a, logic [VecW-1:0] b);
    logic [VecW-1:0] r;
    r = '0;
    for (int i = 0; i < Lanes; i++) r[i*LaneW +: LaneW] = a[i*LaneW +: LaneW] * b[i*LaneW +: LaneW];
    return r;
  endfunction
`else
  typedef enum logic [1:0] {StIdle, StResp} exe_state_e;
`endif

  exe_state_e      exe_state;
  exe_rsp_t        exe_rsp_q;
  vec_op_e         exe_op;
  logic            exe_sup;
  vec_op_e         ln_op;
  logic [VecW-1:0] ln_a;
  logic [VecW-1:0] ln_b;
  logic [VecW-1:0] ln_vd;
  logic [RegW-1:0] ln_rd;

  assign exe_slv.req_ready = rstn && (exe_state == StIdle);
  assign exe_slv.rsp_valid = rstn && (exe_state == StResp);
  assign exe_slv.rsp       = exe_rsp_q;
  assign exe_op            = vec_op_e'(exe_slv.req.instr[14:12]);
  assign exe_sup           = op_supported(exe_slv.req.instr);

  // In BUSY the lanes finish VMAC as vs3 + registered products.
  always_comb begin
    ln_op = exe_op;
    ln_a  = exe_slv.req.vs1;
    ln_b  = exe_slv.req.vs2;
`ifdef XADAC_VEC_ALU_MAC_EN
    if (exe_state == StBusy) begin
      ln_op = VecMac;
      ln_a  = vs3_p0;
      ln_b  = prod_p0;
    end
`endif
  end

  xadac_vec_lanes #(.LaneW(LaneW)) u_lanes (
    .op  (ln_op),
    .a   (ln_a),
    .b   (ln_b),
    .rs1 (exe_slv.req.rs1),
    .idx (exe_slv.req.instr[24:20]),
    .vd  (ln_vd),
    .rd  (ln_rd)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      exe_state <= StIdle;
      exe_rsp_q <= '0;
`ifdef XADAC_VEC_ALU_MAC_EN
      cnt_q     <= '0;
`endif
    end else begin
      unique case (exe_state)
        StIdle: if (exe_slv.req_valid) begin
          exe_rsp_q    <= '0;
          exe_rsp_q.id <= exe_slv.req.id;
          exe_state    <= StResp;
          if (exe_sup) begin
`ifdef XADAC_VEC_ALU_MAC_EN
            if (exe_op == VecMac) begin
              cnt_q     <= CntW'(MacLatency);
              exe_state <= StBusy;
            end else
`endif
            if (exe_op == VecExt) begin
              exe_rsp_q.rd       <= ln_rd;
              exe_rsp_q.rd_write <= 1'b1;
            end else begin
              exe_rsp_q.vd       <= ln_vd;
              exe_rsp_q.vd_write <= 1'b1;
            end
          end
        end
`ifdef XADAC_VEC_ALU_MAC_EN
        StBusy: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            exe_rsp_q.vd       <= ln_vd;
            exe_rsp_q.vd_write <= 1'b1;
            exe_state          <= StResp;
          end
        end
`endif
        StResp: if (exe_slv.rsp_ready) exe_state <= StIdle;
        default: exe_state <= StIdle;
      endcase
    end
  end

`ifdef XADAC_VEC_ALU_MAC_EN
  // Multiply stage: lane products captured at the IDLE handshake
  always_ff @(posedge clk) begin
    if (exe_state == StIdle && exe_slv.req_valid) begin
      vs3_p0  <= exe_slv.req.vs3;
      prod_p0 <= lane_mul(exe_slv.req.vs1, exe_slv.req.vs2);
    end
  end
`endif

endmodule

// File: tb/tb_xadac_vec_alu.sv
// Scoreboard bench for xadac_vec_alu: expected responses are queued at drive time
// and compared when the DUT presents them.
module tb_xadac_vec_alu;
  import xadac_pkg::*;

  localparam int MacLat = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  xadac_dec_if dec ();
  xadac_exe_if exe ();

  xadac_vec_alu #(.MacLatency(MacLat), .LaneW(8)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .dec_slv (dec),
    .exe_slv (exe)
  );

  int checks   = 0;
  int failures = 0;
  dec_rsp_t dec_q[$];
  exe_rsp_t exe_q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] idx,
                                     input logic [6:0] f7 = 7'd0, input logic [6:0] opc = 7'b0001011);
    return {f7, idx, 5'd3, f3, 5'd1, opc};
  endfunction

  function automatic logic mac_on();
`ifdef XADAC_VEC_ALU_MAC_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic legal(input logic [31:0] instr);
    if (instr[6:0] != 7'b0001011 || instr[31:25] != 7'd0) return 1'b0;
    case (instr[14:12])
      3'd0, 3'd1, 3'd3, 3'd4: return 1'b1;
      3'd2:                   return mac_on();
      default:                return 1'b0;
    endcase
  endfunction

  function automatic dec_rsp_t model_dec(input IdT id, input logic [31:0] instr);
    dec_rsp_t r;
    r = '{id: id, default: 1'b0};
    if (legal(instr)) begin
      case (instr[14:12])
        3'd0, 3'd1: r = '{id: id, accept: 1, vd_clobber: 1, vs1_read: 1, vs2_read: 1, vs3_read: 0};
        3'd2:       r = '{id: id, accept: 1, vd_clobber: 1, vs1_read: 1, vs2_read: 1, vs3_read: 1};
        3'd3:       r = '{id: id, accept: 1, vd_clobber: 1, vs1_read: 0, vs2_read: 0, vs3_read: 0};
        default:    r = '{id: id, accept: 1, vd_clobber: 0, vs1_read: 1, vs2_read: 0, vs3_read: 0};
      endcase
    end
    return r;
  endfunction

  function automatic exe_rsp_t model_exe(input IdT id, input logic [31:0] instr, input logic [31:0] rs1,
                                         input logic [31:0] vs1, input logic [31:0] vs2, input logic [31:0] vs3);
    exe_rsp_t r;
    logic [7:0] a, b, c, o;
    r = '0;
    r.id = id;
    if (!legal(instr)) return r;
    if (instr[14:12] == 3'd4) begin
      r.rd = (vs1 >> (8 * (int'(instr[24:20]) % 4))) & 32'hFF;
      r.rd_write = 1'b1;
      return r;
    end
    for (int i = 0; i < 4; i++) begin
      a = vs1[8*i +: 8];
      b = vs2[8*i +: 8];
      c = vs3[8*i +: 8];
      case (instr[14:12])
        3'd0:    o = a + b;
        3'd1:    o = a - b;
        3'd2:    o = c + 8'(a * b);
        default: o = rs1[7:0];
      endcase
      r.vd[8*i +: 8] = o;
    end
    r.vd_write = 1'b1;
    return r;
  endfunction

  task automatic dec_run(input IdT id, input logic [31:0] instr, input int hold);
    dec_rsp_t e;
    dec_q.push_back(model_dec(id, instr));
    @(negedge clk);
    dec.req_valid = 1'b1;
    dec.req       = '{id: id, instr: instr};
    dec.rsp_ready = 1'b0;
    chk("dec_req_ready_idle", dec.req_ready, 1'b1);
    @(negedge clk);
    dec.req_valid = 1'b0;
    e = dec_q.pop_front();
    chk("dec_rsp_valid", dec.rsp_valid, 1'b1);
    chk("dec_rsp", dec.rsp, e);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("dec_hold_valid", dec.rsp_valid, 1'b1);
      chk("dec_hold_rsp", dec.rsp, e);
      chk("dec_hold_req_ready", dec.req_ready, 1'b0);
    end
    dec.rsp_ready = 1'b1;
    @(negedge clk);
    dec.rsp_ready = 1'b0;
    chk("dec_rsp_drained", dec.rsp_valid, 1'b0);
  endtask

  task automatic exe_run(input IdT id, input logic [31:0] instr, input logic [31:0] rs1,
                         input logic [31:0] vs1, input logic [31:0] vs2, input logic [31:0] vs3,
                         input int exp_lat);
    exe_rsp_t e;
    int lat;
    int rdy_seen;
    exe_q.push_back(model_exe(id, instr, rs1, vs1, vs2, vs3));
    @(negedge clk);
    exe.req_valid = 1'b1;
    exe.req       = '{id: id, instr: instr, rs1: rs1, vs1: vs1, vs2: vs2, vs3: vs3};
    exe.rsp_ready = 1'b0;
    chk("exe_req_ready_idle", exe.req_ready, 1'b1);
    @(negedge clk);
    exe.req_valid = 1'b0;
    lat = 1;
    rdy_seen = 0;
    while (!exe.rsp_valid && lat < 40) begin
      if (exe.req_ready) rdy_seen++;
      @(negedge clk);
      lat++;
    end
    chk("exe_latency", lat, exp_lat);
    chk("exe_ready_while_busy", rdy_seen, 0);
    e = exe_q.pop_front();
    chk("exe_rsp", exe.rsp, e);
    exe.rsp_ready = 1'b1;
    @(negedge clk);
    exe.rsp_ready = 1'b0;
    chk("exe_back_to_idle", exe.req_ready, 1'b1);
  endtask

  logic [2:0] ops [4] = '{3'd0, 3'd1, 3'd3, 3'd4};

  initial begin
    int seen;
    dec.req_valid = 1'b0; dec.req = '0; dec.rsp_ready = 1'b0;
    exe.req_valid = 1'b0; exe.req = '0; exe.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dec_rsp_valid", dec.rsp_valid, 1'b0);
    chk("rst_exe_rsp_valid", exe.rsp_valid, 1'b0);
    chk("rst_exe_req_ready", exe.req_ready, 1'b0);
    chk("rst_dec_req_ready", dec.req_ready, 1'b1);
    rstn = 1'b1;

    dec_run(4'd2, mk(3'd0, 5'd0), 0);
    dec_run(4'd5, mk(3'd0, 5'd0, 7'd0, 7'b0110011), 3);
    dec_run(4'd6, mk(3'd2, 5'd0), 0);
    dec_run(4'd7, mk(3'd3, 5'd0), 0);
    dec_run(4'd8, mk(3'd4, 5'd0), 1);
    dec_run(4'd9, mk(3'd5, 5'd0), 0);
    dec_run(4'd10, mk(3'd1, 5'd0, 7'd1), 0);

    exe_run(4'd1, mk(3'd0, 5'd0), 32'h0, 32'h01FF7F10, 32'h01018102, 32'h0, 1);
    exe_run(4'd3, mk(3'd4, 5'd2), 32'h0, 32'hAABBCCDD, 32'h0, 32'h0, 1);
    exe_run(4'd4, mk(3'd4, 5'd7), 32'h0, 32'hAABBCCDD, 32'h0, 32'h0, 1);
    exe_run(4'd5, mk(3'd1, 5'd0), 32'h0, 32'h00107F05, 32'h01208006, 32'h0, 1);
    exe_run(4'd6, mk(3'd3, 5'd0), 32'h123456A5, 32'h0, 32'h0, 32'h0, 1);
    exe_run(4'd7, mk(3'd0, 5'd0, 7'h20), 32'h0, 32'h11111111, 32'h1, 32'h0, 1);
    exe_run(4'd8, mk(3'd6, 5'd0), 32'h0, 32'h11111111, 32'h1, 32'h0, 1);
    exe_run(4'd9, mk(3'd2, 5'd0), 32'h0, 32'h02020202, 32'h03030303, 32'h01010101,
            mac_on() ? MacLat + 1 : 1);
    exe_run(4'd10, mk(3'd2, 5'd0), 32'h0, 32'h10FF8003, 32'h10FF0205, 32'hF0010203,
            mac_on() ? MacLat + 1 : 1);

    fork
      dec_run(4'd11, mk(3'd1, 5'd0), 0);
      exe_run(4'd12, mk(3'd0, 5'd0), 32'h0, 32'hFFFFFFFF, 32'h01010101, 32'h0, 1);
    join

    for (int n = 0; n < 10; n++) begin
      logic [31:0] ins;
      ins = mk(ops[$urandom_range(0, 3)], 5'($urandom_range(0, 31)));
      exe_run(IdT'(n), ins, $urandom, $urandom, $urandom, $urandom, 1);
      dec_run(IdT'(n + 3), ins, n % 2);
    end

    // Reset while an operation is outstanding (BUSY with MAC, otherwise an unacknowledged RESP)
    @(negedge clk);
    exe.req_valid = 1'b1;
    exe.req = '{id: 4'd13, instr: mk(mac_on() ? 3'd2 : 3'd0, 5'd0), rs1: 32'h0,
                vs1: 32'h02020202, vs2: 32'h03030303, vs3: 32'h01010101};
    @(negedge clk);
    exe.req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (exe.rsp_valid) seen++;
    end
    chk("no_rsp_after_reset", seen, 0);
    chk("idle_after_reset", exe.req_ready, 1'b1);
    exe_run(4'd14, mk(3'd0, 5'd0), 32'h0, 32'h01FF7F10, 32'h01018102, 32'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xadac_vec_alu.md
XADAC_VEC_ALU -- requirements
Module: xadac_vec_alu

Interface
REQ-001 SHALL have parameter MacLatency, default 3, meaning the number of BUSY cycles a VMAC spends before its response.
REQ-002 SHALL have parameter LaneW, default 8, meaning the lane width in bits; VecW is divisible by LaneW.
REQ-003 SHALL have port clk, input, 1 bit, the clock.
REQ-004 SHALL have port rstn, input, 1 bit, a synchronous active-low reset.
REQ-005 SHALL have port dec_slv, xadac_dec_if.slv, carrying the decode req {id, instr} and the decode rsp {id, accept, vd_clobber, vs1_read, vs2_read, vs3_read}.
REQ-006 SHALL have port exe_slv, xadac_exe_if.slv, carrying the execute req {id, instr, rs1, vs1, vs2, vs3} and the execute rsp {id, rd, rd_write, vd, vd_write}.

Function
REQ-007 SHALL terminate both xadac interfaces as the responder end; every accepted req yields exactly one rsp carrying the same id.
REQ-008 SHALL accept an instruction only when all of the following hold: instr[6:0]=7'b0001011 (custom-0), instr[31:25]=0, and funct3 selects a supported op.
- funct3 0: VADD, vd = lane-wise vs1+vs2.
- funct3 1: VSUB, vd = lane-wise vs1-vs2.
- funct3 2: VMAC, vd = lane-wise vs3+vs1*vs2.
- funct3 3: VBCAST, every lane = rs1[LaneW-1:0].
- funct3 4: VEXT, rd = zero-extended lane rs2-field index (instr[24:20] mod lanes) of vs1.
REQ-009 SHALL give lane arithmetic modulo 2^LaneW, with no carry between lanes; VMAC keeps the low LaneW bits of the product and of the sum.
REQ-010 SHALL produce the decode rsp from a one-entry registered buffer, so rsp_valid rises the cycle after the req handshake.
REQ-011 SHALL hold dec rsp_valid and its data stable until rsp_ready.
REQ-012 SHALL drive dec req_ready = !rsp_pending || rsp_ready, allowing back-to-back decodes.
REQ-013 SHALL set the dec rsp fields as follows:
- Rejected instr: accept=0 and every other flag 0.
- VADD/VSUB/VMAC: vd_clobber=1, vs1_read=1, vs2_read=1.
- VMAC: additionally vs3_read=1.
- VBCAST: vd_clobber=1 only.
- VEXT: vs1_read=1 only.
REQ-014 SHALL run the execute path as an FSM with states IDLE, BUSY and RESP; exe req_ready=1 only in IDLE.
REQ-015 SHALL register the operands on an IDLE handshake, then go to BUSY for VMAC or to RESP for any other op.
REQ-016 SHALL leave BUSY for RESP after exactly MacLatency cycles, counted by a down-counter.
REQ-017 SHALL assert exe rsp_valid in RESP, return to IDLE on rsp_ready, and add no extra bubble: the next req can handshake the cycle after.
REQ-018 SHALL set vd_write=1 only for VADD, VSUB, VMAC and VBCAST, and rd_write=1 only for VEXT; unused result fields are 0.
REQ-019 SHALL allow a dec handshake and an exe handshake in the same cycle, processed independently.
REQ-020 SHALL, on an exe req whose instr decodes as unsupported (a protocol violation), respond in 1 cycle with rd_write=0 and vd_write=0 and never hang.

Reset
REQ-021 SHALL, while rstn=0 at a clk edge, clear the following: FSM to IDLE, counter to 0, rsp_pending to 0, and all rsp data registers to 0.
REQ-022 SHALL hold dec rsp_valid=0, exe rsp_valid=0 and exe req_ready=0 while rstn=0; dec req_ready then evaluates to 1 because rsp_pending=0.
REQ-023 SHALL abandon any in-flight BUSY operation on a mid-operation reset, with no response issued afterward.

Configuration
REQ-024 SHALL compile VMAC, the multiplier, the BUSY state and the counter in when the macro XADAC_VEC_ALU_MAC_EN is defined.
REQ-025 SHALL, without XADAC_VEC_ALU_MAC_EN, decode funct3 2 as unsupported (accept=0), and the FSM SHALL use only IDLE and RESP.

Structure
REQ-026 SHALL place the following in xadac_pkg:
- Opcode constant XadacOpcode.
- funct3 enum vec_op_e.
- Constants VecW and LaneW.
- Existing IdT and RegIdT.
REQ-027 SHALL instantiate one sub-module, xadac_vec_lanes: combinational lane arithmetic selected by vec_op_e, with the registered multiply stage handled in the parent.

Verification
REQ-028 SHALL cover: dec VADD instr (funct3 0, custom-0, id 2) -> next cycle rsp id 2, accept=1, vd_clobber=1, vs1_read=1, vs2_read=1, vs3_read=0.
REQ-029 SHALL cover: dec instr with opcode 7'b0110011 -> rsp accept=0 with all flags 0; with rsp_ready held 0 for 3 cycles, req_ready=0 and the rsp stays stable.
REQ-030 SHALL cover: exe VADD, vs1=32'h01FF7F10, vs2=32'h01018102 -> vd=32'h0200_0012, vd_write=1, rsp one cycle after handshake.
REQ-031 SHALL cover: exe VMAC with MacLatency=3, vs1=32'h02020202, vs2=32'h03030303, vs3=32'h01010101 -> vd=32'h07070707, rsp_valid exactly 4 cycles after handshake, req_ready=0 meanwhile.
REQ-032 SHALL cover: exe VEXT, lane index 2, vs1=32'hAABBCCDD -> rd=32'h000000BB, rd_write=1, vd_write=0.
REQ-033 SHALL cover: rstn=0 during VMAC BUSY -> no rsp_valid afterward; the next VADD completes normally.
